// File: rtl/ir_beacon_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ir_beacon_tx
//  Description : IR goal-beacon transmitter. Drives the beacon LED with a
//                low/high frequency square-wave carrier, either continuous
//                or as bursts of BURST_PERIODS periods separated by GAP_CLKS
//                dark clocks. Frequency/mode changes only land on period
//                boundaries, so the carrier never emits a runt half-period.
//  Revision    : 1.0  initial release
// ============================================================================
module ir_beacon_tx #(
   parameter int CLK_HZ        = 100000000,
   parameter int F_LOW_HZ      = 1000,
   parameter int F_HIGH_HZ     = 10000,
   parameter int BURST_PERIODS = 8,
   parameter int GAP_CLKS      = 400000
) (
   input  logic clk,
   input  logic Reset,
   input  logic Enable,
   input  logic Freq_Sel,
   input  logic Burst_Mode,
   output logic IR_LED,
   output logic Active,
   output logic Cycle_Tick
);

   localparam int HALF_LO  = CLK_HZ / (2 * F_LOW_HZ);
   localparam int HALF_HI  = CLK_HZ / (2 * F_HIGH_HZ);
   localparam int HALF_MAX = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
   localparam int HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
   localparam int PER_W    = $clog2(BURST_PERIODS + 1);
   localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            r_state,  w_state;
   logic [HALF_W-1:0] r_half,   w_half;
   logic [PER_W-1:0]  r_per,    w_per;
   logic [GAP_W-1:0]  r_gap,    w_gap;
   logic              r_sel,    w_sel;
   logic              r_burst,  w_burst;
   logic              r_led,    w_led;
   logic              r_active, w_active;
   logic              r_tick,   w_tick;

   logic [HALF_W-1:0] w_half_last;
   logic [PER_W-1:0]  w_per_inc;

   // Last half-period count for the frequency latched at the period start.
   assign w_half_last = r_sel ? HALF_W'(HALF_HI - 1) : HALF_W'(HALF_LO - 1);
   assign w_per_inc   = r_per + 1'b1;

   // State and output registers; the async clear pulls the LED dark at once.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= S_IDLE;
         r_half   <= '0;
         r_per    <= '0;
         r_gap    <= '0;
         r_sel    <= 1'b0;
         r_burst  <= 1'b0;
         r_led    <= 1'b0;
         r_active <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_half   <= w_half;
         r_per    <= w_per;
         r_gap    <= w_gap;
         r_sel    <= w_sel;
         r_burst  <= w_burst;
         r_led    <= w_led;
         r_active <= w_active;
         r_tick   <= w_tick;
      end
   end

   // Next-state and carrier sequencing.
   always_comb begin
      w_state  = r_state;
      w_half   = r_half;
      w_per    = r_per;
      w_gap    = r_gap;
      w_sel    = r_sel;
      w_burst  = r_burst;
      w_led    = r_led;
      w_active = r_active;
      w_tick   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (Enable) begin
               w_state  = S_ON;
               w_led    = 1'b1;
               w_active = 1'b1;
               w_half   = '0;
               w_per    = '0;
               w_gap    = '0;
               w_sel    = Freq_Sel;
               w_burst  = Burst_Mode;
            end
         end

         S_ON: begin
            if (r_half == w_half_last) begin
               w_half = '0;
               if (r_led) begin
                  w_led = 1'b0;
               end else begin
                  // Period end: the only point where inputs are honoured.
                  w_tick  = 1'b1;
                  w_sel   = Freq_Sel;
                  w_burst = Burst_Mode;
                  // Wrap rather than overflow while running continuous.
                  w_per   = (w_per_inc == PER_W'(BURST_PERIODS)) ? '0 : w_per_inc;
                  if (!Enable) begin
                     w_state  = S_IDLE;
                     w_active = 1'b0;
                     w_per    = '0;
                  end else if (r_burst && (w_per_inc == PER_W'(BURST_PERIODS))) begin
                     w_state  = S_GAP;
                     w_active = 1'b0;
                     w_gap    = '0;
                     w_per    = '0;
                  end else begin
                     w_led = 1'b1;
                  end
               end
            end else begin
               w_half = r_half + 1'b1;
            end
         end

         S_GAP: begin
            if (!Enable) begin
               w_state = S_IDLE;
               w_gap   = '0;
            end else if (r_gap == GAP_W'(GAP_CLKS - 1)) begin
               w_state  = S_ON;
               w_led    = 1'b1;
               w_active = 1'b1;
               w_half   = '0;
               w_per    = '0;
               w_gap    = '0;
               w_sel    = Freq_Sel;
               w_burst  = Burst_Mode;
            end else begin
               w_gap = r_gap + 1'b1;
            end
         end

         default: begin
            w_state  = S_IDLE;
            w_led    = 1'b0;
            w_active = 1'b0;
         end
      endcase
   end

   assign IR_LED     = r_led;
   assign Active     = r_active;
   assign Cycle_Tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_ir_beacon_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ir_beacon_tx
//  Description : Directed self-checking bench for ir_beacon_tx using small
//                parameters (HALF_LO=5, HALF_HI=2, 3-period bursts, 7 gap).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ir_beacon_tx;

   logic clk;
   logic Reset;
   logic Enable;
   logic Freq_Sel;
   logic Burst_Mode;
   logic IR_LED;
   logic Active;
   logic Cycle_Tick;

   int compared;
   int mismatched;

   ir_beacon_tx #(
      .CLK_HZ        (1000),
      .F_LOW_HZ      (100),
      .F_HIGH_HZ     (250),
      .BURST_PERIODS (3),
      .GAP_CLKS      (7)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .Enable     (Enable),
      .Freq_Sel   (Freq_Sel),
      .Burst_Mode (Burst_Mode),
      .IR_LED     (IR_LED),
      .Active     (Active),
      .Cycle_Tick (Cycle_Tick)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input int idx, input logic el, input logic ea, input logic et);
      chk({tag, ".led"},    idx, IR_LED,     el);
      chk({tag, ".active"}, idx, Active,     ea);
      chk({tag, ".tick"},   idx, Cycle_Tick, et);
   endtask

   initial begin
      logic el, ea, et;
      int   d, p;
      compared   = 0;
      mismatched = 0;
      Reset      = 1'b0;
      Enable     = 1'b0;
      Freq_Sel   = 1'b0;
      Burst_Mode = 1'b0;

      // Reset held across edges: everything dark.
      step();
      step();
      chk3("reset", 0, 1'b0, 1'b0, 1'b0);
      Reset = 1'b1;
      step();
      chk3("idle", 0, 1'b0, 1'b0, 1'b0);

      // Continuous low carrier (5/5), then switch to high at clock 3 of a high
      // half (cycle 33); the switch lands at the period end on cycle 41.
      Enable = 1'b1;
      for (int c = 1; c <= 52; c++) begin
         step();
         if (c <= 40) begin
            el = ((c - 1) % 10) < 5;
            et = (c > 1) && (((c - 1) % 10) == 0);
         end else begin
            d  = c - 41;
            el = (d % 4) < 2;
            et = (d % 4) == 0;
         end
         chk3("cont", c, el, 1'b1, et);
         if (c == 33) Freq_Sel = 1'b1;
      end

      // Back to low frequency: takes effect at period end on cycle 53.
      // Enable drops at clock 2 of the high half; the period still completes.
      Freq_Sel = 1'b0;
      for (int c = 53; c <= 70; c++) begin
         step();
         if (c <= 62) begin
            el = (c <= 57);
            ea = 1'b1;
            et = (c == 53);
         end else begin
            el = 1'b0;
            ea = 1'b0;
            et = (c == 63);
         end
         chk3("dis", c, el, ea, et);
         if (c == 54) Enable = 1'b0;
      end

      // Burst mode at high frequency: 3 x 4-clk periods, 7 dark, repeat.
      Freq_Sel   = 1'b1;
      Burst_Mode = 1'b1;
      Enable     = 1'b1;
      for (int b = 1; b <= 35; b++) begin
         step();
         p = (b - 1) % 19;
         if (p < 12) begin
            el = (p % 4) < 2;
            ea = 1'b1;
            et = ((p % 4) == 0) && (p != 0);
         end else begin
            el = 1'b0;
            ea = 1'b0;
            et = (p == 12);
         end
         chk3("burst", b, el, ea, et);
      end

      // Disable at gap clock 3: IDLE on the next edge, and a re-enable then
      // lights the LED one clock later instead of finishing the gap.
      Enable = 1'b0;
      step();
      chk3("gapdis", 36, 1'b0, 1'b0, 1'b0);
      Enable = 1'b1;
      step();
      chk3("gapdis", 37, 1'b1, 1'b1, 1'b0);
      step();
      chk3("gapdis", 38, 1'b1, 1'b1, 1'b0);
      step();
      chk3("gapdis", 39, 1'b0, 1'b1, 1'b0);
      step();
      chk3("gapdis", 40, 1'b0, 1'b1, 1'b0);
      step();
      chk3("gapdis", 41, 1'b1, 1'b1, 1'b1);

      // Async reset between edges while LED high and tick asserted.
      Freq_Sel   = 1'b0;
      Burst_Mode = 1'b0;
      #2;
      Reset = 1'b0;
      #1;
      chk3("areset", 0, 1'b0, 1'b0, 1'b0);
      step();
      chk3("areset", 1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      Reset = 1'b1;
      for (int r = 1; r <= 7; r++) begin
         step();
         chk3("restart", r, (r <= 5), 1'b1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
